// File: rtl/lfsr_run_sched_pkg.sv
// Shared types and defaults for the LFSR run scheduler.
package lfsr_run_sched_pkg;

    localparam int unsigned LFSR_LEN_DEF  = 22;
    localparam int unsigned FLUSH_CYC_DEF = 2;
    localparam int unsigned NPER_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lfsr_run_sched_period_counter.sv
// Symbol counter over one LFSR period (0..2^LFSR_LEN-2) with a wrap strobe.
module lfsr_period_counter
    import lfsr_run_sched_pkg::*;
#(
    parameter int unsigned LFSR_LEN = LFSR_LEN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    output logic [LFSR_LEN-1:0] sym_count,
    output logic                period_done
);

    // PERIOD-1 = 2^LFSR_LEN - 2: all ones except the LSB.
    localparam logic [LFSR_LEN-1:0] LAST_SYM = {{(LFSR_LEN-1){1'b1}}, 1'b0};

    logic [LFSR_LEN-1:0] count_q, count_d;

    always_comb begin
        period_done = inc && (count_q == LAST_SYM);
        count_d     = count_q;
        if (clear || period_done) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + LFSR_LEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sym_count = count_q;

endmodule

// File: rtl/lfsr_run_sched.sv
// Run scheduler: flushes the LFSR, gates sym_en for N periods and strobes the accumulator.
module lfsr_run_sched
    import lfsr_run_sched_pkg::*;
#(
    parameter int unsigned LFSR_LEN  = LFSR_LEN_DEF,
    parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int unsigned NPER_W    = NPER_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sym_en,
    input  logic                start,
    input  logic                abort,
    input  logic [NPER_W-1:0]   num_periods,
    output logic                lfsr_reset,
    output logic                lfsr_clk_en,
    output logic                acc_clear,
    output logic                acc_window,
    output logic                acc_dump,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [NPER_W-1:0]   period_idx,
    output logic [LFSR_LEN-1:0] sym_count
);

    localparam int unsigned FW = cnt_width(FLUSH_CYC);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    state_e            state_q, state_d;
    logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [NPER_W-1:0] nper_q, nper_d;
    logic [NPER_W-1:0] period_idx_q, period_idx_d;
    logic [NPER_W-1:0] pidx_inc;
    logic              lfsr_reset_q, lfsr_reset_d;
    logic              acc_clear_q, acc_clear_d;
    logic              acc_window_q, acc_window_d;
    logic              acc_dump_q, acc_dump_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              cnt_clear;
    logic              period_done;

    // Abort gates the enable in the same cycle so the LFSR never sees a late symbol.
    assign lfsr_clk_en = sym_en && (state_q == ST_RUN) && !abort && !reset;
    assign pidx_inc    = period_idx_q + NPER_W'(1);

    lfsr_period_counter #(
        .LFSR_LEN (LFSR_LEN)
    ) u_period_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear),
        .inc         (lfsr_clk_en),
        .sym_count   (sym_count),
        .period_done (period_done)
    );

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        nper_d       = nper_q;
        period_idx_d = period_idx_q;
        lfsr_reset_d = 1'b0;
        acc_clear_d  = 1'b0;
        acc_window_d = 1'b0;
        acc_dump_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        cnt_clear    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d      = ST_FLUSH;
                    flush_cnt_d  = '0;
                    nper_d       = num_periods;
                    period_idx_d = '0;
                    cnt_clear    = 1'b1;
                    lfsr_reset_d = 1'b1;
                    acc_clear_d  = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    state_d      = ST_RUN;
                    acc_window_d = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    flush_cnt_d  = flush_cnt_q + FW'(1);
                    lfsr_reset_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    acc_window_d = 1'b1;
                    busy_d       = 1'b1;
                    if (period_done) begin
                        acc_dump_d = 1'b1;
                        if (period_idx_q != '1) begin
                            period_idx_d = pidx_inc;
                        end
                        if ((nper_q != '0) && (pidx_inc == nper_q)) begin
                            state_d      = ST_IDLE;
                            done_d       = 1'b1;
                            acc_window_d = 1'b0;
                            busy_d       = 1'b0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            nper_q       <= '0;
            period_idx_q <= '0;
            lfsr_reset_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            acc_window_q <= 1'b0;
            acc_dump_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            nper_q       <= nper_d;
            period_idx_q <= period_idx_d;
            lfsr_reset_q <= lfsr_reset_d;
            acc_clear_q  <= acc_clear_d;
            acc_window_q <= acc_window_d;
            acc_dump_q   <= acc_dump_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign lfsr_reset = lfsr_reset_q;
    assign acc_clear  = acc_clear_q;
    assign acc_window = acc_window_q;
    assign acc_dump   = acc_dump_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign period_idx = period_idx_q;

endmodule

// File: tb/tb_lfsr_run_sched.sv
// Bench for lfsr_run_sched: scenario table, hand-written corner sequences and a
// randomized phase checked cycle by cycle against a symbol-total reference model.
module tb_lfsr_run_sched;

    localparam int unsigned LL = 4;
    localparam int unsigned FC = 2;
    localparam int unsigned NW = 8;
    localparam int PERIOD = 15;

    logic clk = 1'b0;
    logic reset = 1'b1, sym_en = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NW-1:0] num_periods = '0;
    logic lfsr_reset, lfsr_clk_en, acc_clear, acc_window, acc_dump, busy, done, aborted;
    logic [NW-1:0] period_idx;
    logic [LL-1:0] sym_count;

    lfsr_run_sched #(.LFSR_LEN(LL), .FLUSH_CYC(FC), .NPER_W(NW)) dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .start(start), .abort(abort),
        .num_periods(num_periods), .lfsr_reset(lfsr_reset), .lfsr_clk_en(lfsr_clk_en),
        .acc_clear(acc_clear), .acc_window(acc_window), .acc_dump(acc_dump),
        .busy(busy), .done(done), .aborted(aborted), .period_idx(period_idx),
        .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int se_mode = 0;  // 0: every 4th clk, 1: random, 2: driven by hand
    bit chk_on = 1'b0, mon_on = 1'b0;
    int c_en, c_dump, c_done, c_done_dump, c_abt, c_clear, c_lrst;

    // Reference model: a run is tracked as the total number of enabled symbols.
    int m_phase = 0;  // 0 idle, 1 flush, 2 run
    int m_flush = 0, m_tot = 0, m_nper = 0;
    bit e_clear = 0, e_dump = 0, e_done = 0, e_abt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (se_mode == 0) sym_en = (cyc % 4 == 0);
        else if (se_mode == 1) sym_en = ($urandom_range(0, 3) == 0);
    endtask

    task automatic clear_counts();
        c_en = 0; c_dump = 0; c_done = 0; c_done_dump = 0; c_abt = 0; c_clear = 0; c_lrst = 0;
    endtask

    initial forever begin
        @(posedge clk);
        e_clear = 0; e_dump = 0; e_done = 0; e_abt = 0;
        if (reset) begin
            m_phase = 0; m_tot = 0;
        end else if (m_phase == 0) begin
            if (start && !abort) begin
                m_phase = 1; m_flush = FC; m_nper = int'(num_periods); m_tot = 0; e_clear = 1;
            end
        end else if (abort) begin
            m_phase = 0; e_abt = 1;
        end else if (m_phase == 1) begin
            m_flush--;
            if (m_flush == 0) m_phase = 2;
        end else if (sym_en) begin
            m_tot++;
            if (m_tot % PERIOD == 0) begin
                e_dump = 1;
                if (m_nper != 0 && m_tot / PERIOD == m_nper) begin
                    e_done = 1; m_phase = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            c_en += int'(lfsr_clk_en); c_dump += int'(acc_dump); c_done += int'(done);
            c_done_dump += int'(done && acc_dump); c_abt += int'(aborted);
            c_clear += int'(acc_clear); c_lrst += int'(lfsr_reset);
        end
        if (chk_on) begin
            check("m_busy", busy, m_phase != 0);
            check("m_lfsr_reset", lfsr_reset, m_phase == 1);
            check("m_acc_window", acc_window, m_phase == 2);
            check("m_acc_clear", acc_clear, e_clear);
            check("m_acc_dump", acc_dump, e_dump);
            check("m_done", done, e_done);
            check("m_aborted", aborted, e_abt);
            check("m_clk_en", lfsr_clk_en, sym_en && m_phase == 2 && !abort && !reset);
            check("m_sym_count", sym_count, m_tot % PERIOD);
            check("m_period_idx", period_idx, (m_tot / PERIOD > 255) ? 255 : m_tot / PERIOD);
        end
    end

    typedef struct {
        int nper;
        int abort_after;  // enables before abort, -1 = none
        int exp_en;
        int exp_dump;
        int exp_done;
        int exp_abt;
        int exp_pidx;
    } vec_t;

    task automatic wait_cond(input int which, input int target, input string tag);
        bit hit = 1'b0;
        for (int t = 0; t < 4000 && !hit; t++) begin
            if (which == 0) hit = (c_en >= target);
            else hit = !busy;
            if (!hit) tick();
        end
        if (!hit) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_counts(); mon_on = 1'b1;
        num_periods = NW'(v.nper); start = 1'b1; tick(); start = 1'b0;
        if (v.abort_after >= 0) begin
            wait_cond(0, v.abort_after, tag);
            abort = 1'b1; tick(); abort = 1'b0;
        end else begin
            wait_cond(1, 0, tag);
        end
        tick(); tick(); tick();
        mon_on = 1'b0;
        check({tag, "_enables"}, c_en, v.exp_en);
        check({tag, "_dumps"}, c_dump, v.exp_dump);
        check({tag, "_done"}, c_done, v.exp_done);
        check({tag, "_done_with_dump"}, c_done_dump, v.exp_done);
        check({tag, "_aborted"}, c_abt, v.exp_abt);
        check({tag, "_period_idx"}, period_idx, v.exp_pidx);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_clear_cycles"}, c_clear, 1);
        check({tag, "_lfsr_reset_cycles"}, c_lrst, FC);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{1, -1, 15, 1, 1, 0, 1};
        vecs[1] = '{2, -1, 30, 2, 1, 0, 2};
        vecs[2] = '{3, -1, 45, 3, 1, 0, 3};
        vecs[3] = '{0, 75, 75, 5, 0, 1, 5};
        vecs[4] = '{2, 20, 20, 1, 0, 1, 1};

        reset = 1'b1; tick(); chk_on = 1'b1; tick();
        check("rst_busy", busy, 0);
        check("rst_sym_count", sym_count, 0);
        check("rst_period_idx", period_idx, 0);
        check("rst_lfsr_reset", lfsr_reset, 0);
        reset = 1'b0; tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Abort in the second FLUSH cycle.
        clear_counts(); mon_on = 1'b1;
        num_periods = 8'd1; start = 1'b1; tick(); start = 1'b0; tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("flush_abort_lfsr_reset", lfsr_reset, 0);
        check("flush_abort_aborted", aborted, 1);
        check("flush_abort_busy", busy, 0);
        tick(); tick(); tick(); tick(); tick();
        mon_on = 1'b0;
        check("flush_abort_enables", c_en, 0);

        // Start together with abort in IDLE.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_aborted", aborted, 0);
        check("start_abort_lfsr_reset", lfsr_reset, 0);
        tick();

        // Start re-pulsed mid-run with a different count is ignored.
        clear_counts(); mon_on = 1'b1;
        num_periods = 8'd1; start = 1'b1; tick(); start = 1'b0;
        wait_cond(0, 5, "restart");
        num_periods = 8'd3; start = 1'b1; tick(); start = 1'b0;
        wait_cond(1, 0, "restart");
        tick(); tick(); mon_on = 1'b0;
        check("restart_enables", c_en, 15);
        check("restart_period_idx", period_idx, 1);
        check("restart_done", c_done, 1);

        // Reset mid-run at sym_count 7, then a clean single-period run.
        se_mode = 2; sym_en = 1'b0;
        num_periods = 8'd2; start = 1'b1; tick(); start = 1'b0; tick(); tick();
        for (int i = 0; i < 7; i++) begin sym_en = 1'b1; tick(); end
        sym_en = 1'b0;
        check("pre_reset_sym_count", sym_count, 7);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_window", acc_window, 0);
        check("midrst_sym_count", sym_count, 0);
        check("midrst_period_idx", period_idx, 0);
        check("midrst_pulses", {acc_clear, acc_dump, done, aborted, lfsr_reset}, 0);
        se_mode = 0; tick();
        run_vec('{1, -1, 15, 1, 1, 0, 1}, "post_reset");

        // Final symbol of a one-period run coincident with abort.
        se_mode = 2; sym_en = 1'b0;
        num_periods = 8'd1; start = 1'b1; tick(); start = 1'b0; tick(); tick();
        for (int i = 0; i < 14; i++) begin sym_en = 1'b1; tick(); end
        abort = 1'b1;
        #1 check("coinc_clk_en", lfsr_clk_en, 0);
        tick(); sym_en = 1'b0; abort = 1'b0;
        check("coinc_aborted", aborted, 1);
        check("coinc_done", done, 0);
        check("coinc_dump", acc_dump, 0);
        check("coinc_sym_count", sym_count, 14);
        tick();
        check("coinc_done_late", done, 0);

        // Randomized traffic against the model.
        se_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 399) == 0);
            num_periods = NW'($urandom_range(0, 3));
            tick();
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
